// File: rtl/ysyx_22050078_pipe_hs_reg_pkg.sv
// Shared bundle widths, bubble encodings and handshake state helpers
// for the handshaked stage registers between pipeline stages.
package ysyx_22050078_pipe_hs_reg_pkg;

  localparam int CPU_WIDTH = 32;
  localparam int REG_ADDRW = 5;

  localparam int ID_EX_W = 4*CPU_WIDTH+REG_ADDRW+16;
  localparam int EX_LS_W = 3*CPU_WIDTH+REG_ADDRW+6;
  localparam int LS_WB_W = CPU_WIDTH+REG_ADDRW+1;

  // All-zero bundles: rdwen, lden and sten stay low.
  localparam logic [ID_EX_W-1:0] ID_EX_BUBBLE = '0;
  localparam logic [EX_LS_W-1:0] EX_LS_BUBBLE = '0;
  localparam logic [LS_WB_W-1:0] LS_WB_BUBBLE = '0;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } hs_state_e;

  function automatic hs_state_e hs_state(
    input logic m,
    input logic s
  );
    if (s)      return FULL;
    else if (m) return BUSY;
    else        return EMPTY;
  endfunction

endpackage

// File: rtl/ysyx_22050078_pipe_hs_reg_slot.sv
// One storage slot: a valid bit plus a payload register.
// Init wins over load, load wins over clear; clear keeps the payload.
module ysyx_22050078_pipe_slot
  import ysyx_22050078_pipe_hs_reg_pkg::*;
#(
  parameter int               WIDTH     = EX_LS_W,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_init,
  input  logic             i_load,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_din,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_dout
);

  always_ff @(posedge i_clk) begin
    if (i_init) begin
      o_valid <= 1'b0;
      o_dout  <= RESET_VAL;
    end else if (i_load) begin
      o_valid <= 1'b1;
      o_dout  <= i_din;
    end else if (i_clear) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ysyx_22050078_pipe_hs_reg.sv
// Handshaked pipeline register with flush and optional skid slot.
// With SKID=1 the upstream ready comes from registers only.
module ysyx_22050078_pipe_hs_reg
  import ysyx_22050078_pipe_hs_reg_pkg::*;
#(
  parameter int               WIDTH     = EX_LS_W,
  parameter logic [WIDTH-1:0] RESET_VAL = EX_LS_BUBBLE,
  parameter bit               SKID      = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_din,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_dout,
  output logic [1:0]       o_count
);

  logic m_valid;
  logic s_valid;
  logic accept;
  logic pop;
  logic init;
  logic m_load;
  logic m_clear;
  logic [WIDTH-1:0] m_din;

  assign init    = i_rst | i_flush;
  assign accept  = i_valid & o_ready;
  assign pop     = m_valid & i_ready;
  assign o_valid = m_valid;
  assign o_count = {1'b0, m_valid} + {1'b0, s_valid};

  ysyx_22050078_pipe_slot #(
    .WIDTH    (WIDTH),
    .RESET_VAL(RESET_VAL)
  ) u_m (
    .i_clk  (i_clk),
    .i_init (init),
    .i_load (m_load),
    .i_clear(m_clear),
    .i_din  (m_din),
    .o_valid(m_valid),
    .o_dout (o_dout)
  );

  generate
    if (SKID) begin : g_skid
      hs_state_e        st;
      logic             s_load;
      logic             s_clear;
      logic [WIDTH-1:0] s_dout;

      assign st      = hs_state(m_valid, s_valid);
      assign o_ready = ~i_rst & ~s_valid;

      always_comb begin
        m_load  = 1'b0;
        m_clear = 1'b0;
        s_load  = 1'b0;
        s_clear = 1'b0;
        m_din   = i_din;
        unique case (st)
          EMPTY: m_load = accept;
          BUSY: begin
            m_load  = accept & pop;
            m_clear = pop & ~accept;
            s_load  = accept & ~pop;
          end
          FULL: begin
            // Head leaves: the parked beat slides into M.
            m_load  = pop;
            s_clear = pop;
            m_din   = s_dout;
          end
          default: ;
        endcase
      end

      ysyx_22050078_pipe_slot #(
        .WIDTH    (WIDTH),
        .RESET_VAL(RESET_VAL)
      ) u_s (
        .i_clk  (i_clk),
        .i_init (init),
        .i_load (s_load),
        .i_clear(s_clear),
        .i_din  (i_din),
        .o_valid(s_valid),
        .o_dout (s_dout)
      );
    end else begin : g_single
      assign s_valid = 1'b0;
      assign o_ready = ~i_rst & (~m_valid | i_ready);
      assign m_din   = i_din;
      assign m_load  = accept;
      assign m_clear = pop & ~accept;
    end
  endgenerate

endmodule

// File: tb/tb_ysyx_22050078_pipe_hs_reg.sv
// Scoreboard bench: SKID=1 and SKID=0 instances share one stimulus
// stream; each keeps its own queue of accepted beats.
module tb_ysyx_22050078_pipe_hs_reg;

  localparam logic [7:0] RV = 8'hC3;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       vld;
  logic       rdy_dn;
  logic [7:0] din;
  logic       rdy1, rdy0;
  logic       ov1, ov0;
  logic [7:0] dout1, dout0;
  logic [1:0] cnt1, cnt0;

  int n_cmp;
  int n_err;
  bit live;
  logic [7:0] q1[$];
  logic [7:0] q0[$];
  logic [7:0] last1, last0;

  ysyx_22050078_pipe_hs_reg #(
    .WIDTH(8), .RESET_VAL(RV), .SKID(1'b1)
  ) dut1 (
    .i_clk(clk), .i_rst(rst), .i_flush(flush),
    .i_valid(vld), .o_ready(rdy1), .i_din(din),
    .o_valid(ov1), .i_ready(rdy_dn),
    .o_dout(dout1), .o_count(cnt1)
  );

  ysyx_22050078_pipe_hs_reg #(
    .WIDTH(8), .RESET_VAL(RV), .SKID(1'b0)
  ) dut0 (
    .i_clk(clk), .i_rst(rst), .i_flush(flush),
    .i_valid(vld), .o_ready(rdy0), .i_din(din),
    .o_valid(ov0), .i_ready(rdy_dn),
    .o_dout(dout0), .o_count(cnt0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    logic [7:0] e1, e0;
    @(negedge clk);
    if (live) begin
      e1 = (q1.size() != 0) ? q1[0] : last1;
      e0 = (q0.size() != 0) ? q0[0] : last0;
      check("rdy1", rdy1, !rst && q1.size() < 2);
      check("rdy0", rdy0,
            !rst && (q0.size() == 0 || rdy_dn));
      check("val1", ov1, q1.size() != 0);
      check("val0", ov0, q0.size() != 0);
      check("cnt1", cnt1, q1.size());
      check("cnt0", cnt0, q0.size());
      check("dout1", dout1, e1);
      check("dout0", dout0, e0);
    end
    if (rst) begin
      q1.delete();
      q0.delete();
      last1 = RV;
      last0 = RV;
      live  = 1'b1;
    end else begin
      if (ov1 && rdy_dn) begin
        if (q1.size() == 0) check("pop1_empty", 1, 0);
        else begin
          check("pop1", dout1, q1[0]);
          last1 = q1.pop_front();
        end
      end
      if (ov0 && rdy_dn) begin
        if (q0.size() == 0) check("pop0_empty", 1, 0);
        else begin
          check("pop0", dout0, q0[0]);
          last0 = q0.pop_front();
        end
      end
      if (flush) begin
        q1.delete();
        q0.delete();
        last1 = RV;
        last0 = RV;
      end else begin
        if (vld && rdy1) q1.push_back(din);
        if (vld && rdy0) q0.push_back(din);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(
    input logic       v,
    input logic [7:0] d,
    input logic       r
  );
    vld    = v;
    din    = d;
    rdy_dn = r;
    step();
  endtask

  task automatic drain();
    flush = 1'b0;
    for (int i = 0; i < 4; i++) drive(1'b0, 8'h00, 1'b1);
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    live   = 1'b0;
    last1  = RV;
    last0  = RV;
    rst    = 1'b1;
    flush  = 1'b0;
    vld    = 1'b0;
    rdy_dn = 1'b0;
    din    = 8'h00;
    @(posedge clk);
    #1;
    step();
    step();
    rst = 1'b0;
    #1;
    check("rst_rdy1", rdy1, 1);
    check("rst_val1", ov1, 0);
    check("rst_dout1", dout1, RV);
    check("rst_cnt1", cnt1, 0);

    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 8'hA0 + 8'(i), 1'b1);
      check("str_dout1", dout1, 8'hA0 + 8'(i));
      check("str_cnt1", cnt1, 1);
      check("str_rdy1", rdy1, 1);
    end
    drain();

    drive(1'b1, 8'h11, 1'b1);
    drive(1'b1, 8'h22, 1'b0);
    drive(1'b1, 8'h33, 1'b0);
    check("skid_cnt", cnt1, 2);
    check("skid_rdy", rdy1, 0);
    check("skid_dout", dout1, 8'h11);
    drive(1'b1, 8'h33, 1'b1);
    check("skid_d22", dout1, 8'h22);
    check("skid_rdy_up", rdy1, 1);
    drive(1'b1, 8'h33, 1'b1);
    check("skid_d33", dout1, 8'h33);
    drain();

    drive(1'b1, 8'h5A, 1'b0);
    check("s0_m5a", dout0, 8'h5A);
    vld    = 1'b1;
    din    = 8'hA5;
    rdy_dn = 1'b1;
    #1;
    check("s0_rdy_comb", rdy0, 1);
    step();
    check("s0_da5", dout0, 8'hA5);
    check("s0_val", ov0, 1);
    drain();

    drive(1'b1, 8'hB1, 1'b0);
    drive(1'b1, 8'hB2, 1'b0);
    check("fl_full", cnt1, 2);
    flush = 1'b1;
    drive(1'b1, 8'hB3, 1'b0);
    flush = 1'b0;
    check("fl_val", ov1, 0);
    check("fl_cnt", cnt1, 0);
    check("fl_dout", dout1, RV);
    drive(1'b0, 8'h00, 1'b1);
    check("fl_gone", ov1, 0);

    drive(1'b1, 8'hC1, 1'b0);
    drive(1'b1, 8'hC2, 1'b0);
    rst = 1'b1;
    #1;
    check("mr_rdy1", rdy1, 0);
    check("mr_rdy0", rdy0, 0);
    drive(1'b1, 8'hC3, 1'b1);
    drive(1'b1, 8'hC4, 1'b1);
    rst = 1'b0;
    vld = 1'b0;
    #1;
    check("mr_rdy_up", rdy1, 1);
    check("mr_val", ov1, 0);
    check("mr_dout", dout1, RV);

    for (int i = 0; i < 600; i++) begin
      flush = ($urandom_range(0, 39) == 0);
      drive($urandom_range(0, 1) == 1,
            8'($urandom),
            $urandom_range(0, 3) != 0);
    end
    drain();
    check("end_q1", q1.size(), 0);
    check("end_q0", q0.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
